// File: rtl/sram_stream_reader.sv
// sram_stream_reader
//   Read-side initiator for a single SRAM bank. Issues sequential reads from
//   base_addr for `length` words. It absorbs the bank's one-cycle read latency
//   in a small credit-controlled FIFO and presents the words as a
//   valid/ready stream.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   start               one-cycle request, sampled only while idle
//   base_addr, length   transfer descriptor, captured with start
//   busy, done          transfer in progress / one-cycle completion pulse
//   sram_en, sram_we,   bank read port (we held low)
//   sram_addr
//   sram_data           bank data_o, valid the cycle after sram_en
//   m_valid, m_ready,   output stream; m_data is the FIFO head and
//   m_data, m_last      m_last marks the final word
module sram_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_done_nxt;

  logic [ADDR_WIDTH-1:0] r_base;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_issue_cnt;
  logic [LEN_WIDTH-1:0]  r_beat_cnt;
  logic                  r_inflight;
  logic                  r_done;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;

  logic                  w_valid;
  logic                  w_push;
  logic                  w_pop;
  logic [CNT_W:0]        w_occ;
  logic                  w_credit;
  logic                  w_issue;
  logic                  w_issue_last;
  logic                  w_is_last_beat;
  logic                  w_final_accept;
  logic                  w_accept_start;

  assign w_valid        = (r_count != '0);
  assign w_pop          = w_valid & m_ready;
  // Data returns one cycle after the strobe, so the in-flight read is the push.
  assign w_push         = r_inflight;
  // Occupancy after this cycle's pop, counting the word still in the SRAM pipe.
  assign w_occ          = {1'b0, r_count} + (CNT_W+1)'(r_inflight) - (CNT_W+1)'(w_pop);
  assign w_credit       = (w_occ < DEPTH_C);
  assign w_issue        = (r_state == S_READ) & w_credit;
  assign w_issue_last   = ((r_issue_cnt + LEN_WIDTH'(1)) == r_len);
  assign w_is_last_beat = (r_beat_cnt == (r_len - LEN_WIDTH'(1)));
  assign w_final_accept = w_pop & w_is_last_beat & (r_state != S_IDLE);
  assign w_accept_start = (r_state == S_IDLE) & start & (length != '0);

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (length != '0) w_state_nxt = S_READ;
          else              w_done_nxt  = 1'b1;
        end
      end
      S_READ: begin
        if (w_issue && w_issue_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_final_accept) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Transfer descriptor and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_base      <= '0;
      r_len       <= '0;
      r_issue_cnt <= '0;
      r_beat_cnt  <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_accept_start) begin
        r_base      <= base_addr;
        r_len       <= length;
        r_issue_cnt <= '0;
        r_beat_cnt  <= '0;
      end else begin
        if (w_issue) r_issue_cnt <= r_issue_cnt + LEN_WIDTH'(1);
        if (w_pop)   r_beat_cnt  <= r_beat_cnt + LEN_WIDTH'(1);
      end
    end
  end

  // Output FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= sram_data;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(w_push && !w_pop && (r_count == CNT_W'(FIFO_DEPTH))));

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign sram_en   = w_issue;
  assign sram_we   = 1'b0;
  // Address wraps modulo 2^ADDR_WIDTH. It reads as zero when no read is issued.
  assign sram_addr = w_issue ? (r_base + ADDR_WIDTH'(r_issue_cnt)) : '0;
  assign m_valid   = w_valid;
  assign m_data    = w_valid ? r_mem[r_rptr] : '0;
  assign m_last    = w_valid & w_is_last_beat;

endmodule

// File: tb/tb_sram_stream_reader.sv
// tb_sram_stream_reader
//   Directed bench for sram_stream_reader with a behavioural one-cycle-latency
//   SRAM bank and a stream monitor. The monitor records the issued addresses,
//   the accepted beats, and the done timing for each transfer.
module tb_sram_stream_reader;

  localparam int DW = 8;
  localparam int AW = 16;
  localparam int LW = 16;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] length = '0;
  logic          busy, done, sram_en, sram_we, m_valid, m_last;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_data = '0;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;

  sram_stream_reader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .LEN_WIDTH (LW),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .length   (length),
    .busy     (busy),
    .done     (done),
    .sram_en  (sram_en),
    .sram_we  (sram_we),
    .sram_addr(sram_addr),
    .sram_data(sram_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [65536];
  always @(posedge clk) if (sram_en) sram_data <= mem[sram_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor state
  int gcyc = 0;
  int c0 = 0;
  always @(posedge clk) gcyc <= gcyc + 1;

  logic [DW-1:0] beats[$];
  bit            lasts[$];
  logic [AW-1:0] addrs[$];
  int en_cnt, acc, done_cnt, done_rel, first_valid, last_acc, stab_err, ovf_err;
  bit done_busy, prev_stall;
  logic [DW-1:0] prev_data;

  task automatic clear_mon();
    beats.delete(); lasts.delete(); addrs.delete();
    en_cnt = 0; acc = 0; done_cnt = 0; done_rel = -1; first_valid = -1;
    last_acc = -1; stab_err = 0; ovf_err = 0; done_busy = 1'b0;
    prev_stall = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (sram_en) begin en_cnt++; addrs.push_back(sram_addr); end
      if (m_valid && first_valid < 0) first_valid = gcyc - c0;
      if (prev_stall && (!m_valid || m_data !== prev_data)) stab_err++;
      if (m_valid && m_ready) begin
        beats.push_back(m_data); lasts.push_back(m_last);
        last_acc = gcyc - c0; acc++;
      end
      if (done) begin done_cnt++; done_rel = gcyc - c0; done_busy = busy; end
      if (en_cnt - acc > FD) ovf_err++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  function automatic logic rdy(input int mode, input int rel);
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    if (mode == 1) begin
      if (rel >= 12 && rel < 22) return 1'b0;
      return pat[rel % 4];
    end
    return 1'b1;
  endfunction

  // Runs one transfer to completion. inj=1 pulses a competing start mid-transfer.
  task automatic run(input string t, input logic [AW-1:0] b, input logic [LW-1:0] l,
                     input int mode, input bit inj);
    clear_mon();
    c0 = gcyc; base_addr = b; length = l; start = 1'b1; m_ready = rdy(mode, 0);
    tick();
    start = 1'b0;
    for (int i = 1; i < 300 && done_cnt == 0; i++) begin
      m_ready = rdy(mode, i);
      if (inj && i == 4) begin start = 1'b1; base_addr = 16'h0030; length = 16'd2; end
      else if (inj && i == 5) start = 1'b0;
      tick();
    end
    chk({t, "_timeout"}, done_cnt > 0, 1);
    tick(); tick();
    m_ready = 1'b0;
  endtask

  task automatic check_common(input string t, input int len);
    chk({t, "_en_cnt"}, en_cnt, len);
    chk({t, "_nbeats"}, beats.size(), len);
    for (int i = 0; i < len && i < lasts.size(); i++)
      chk({t, "_last"}, lasts[i], (i == len - 1));
    chk({t, "_done_once"}, done_cnt, 1);
    chk({t, "_done_time"}, done_rel, last_acc + 1);
    chk({t, "_busy_at_done"}, done_busy, 0);
    chk({t, "_overfill"}, ovf_err, 0);
    chk({t, "_stable"}, stab_err, 0);
  endtask

  logic [DW-1:0] wrap_data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [AW-1:0] wrap_addr [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    for (int i = 0; i < 8; i++) mem[16'h10 + i] = 8'hA0 + 8'(i);
    mem[16'hFFFE] = 8'h11; mem[16'hFFFF] = 8'h22; mem[16'h0000] = 8'h33; mem[16'h0001] = 8'h44;
    mem[16'h20] = 8'h55; mem[16'h21] = 8'h66; mem[16'h40] = 8'h5A;
    clear_mon();

    #1;
    chk("reset_outputs", {busy, done, sram_en, sram_we, sram_addr, m_valid, m_data, m_last}, 0);
    tick(); tick();
    rst = 1'b1;

    // Basic read with full-rate sink
    run("basic", 16'h0010, 16'd8, 0, 1'b0);
    chk("basic_first_valid", first_valid, 3);
    chk("basic_no_bubbles", last_acc - first_valid, 7);
    chk("basic_addr0", addrs.size() > 0 ? addrs[0] : '1, 16'h0010);
    for (int i = 0; i < 8 && i < beats.size(); i++) chk("basic_data", beats[i], 8'hA0 + i);
    check_common("basic", 8);
    chk("basic_busy_after", busy, 0);

    // Backpressure with toggling ready and a long stall
    run("bp", 16'h0010, 16'd8, 1, 1'b0);
    for (int i = 0; i < 8 && i < beats.size(); i++) chk("bp_data", beats[i], 8'hA0 + i);
    check_common("bp", 8);

    // Address wrap
    run("wrap", 16'hFFFE, 16'd4, 0, 1'b0);
    for (int i = 0; i < 4 && i < addrs.size(); i++) chk("wrap_addr", addrs[i], wrap_addr[i]);
    for (int i = 0; i < 4 && i < beats.size(); i++) chk("wrap_data", beats[i], wrap_data[i]);
    check_common("wrap", 4);

    // Zero length
    clear_mon();
    c0 = gcyc; base_addr = 16'h0010; length = '0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_en", sram_en, 0);
    tick();
    chk("zero_done_pulse", done, 0);
    chk("zero_busy2", busy, 0);
    chk("zero_no_reads", en_cnt, 0);

    // Start while busy is ignored
    run("ign", 16'h0010, 16'd8, 0, 1'b1);
    for (int i = 0; i < 8 && i < beats.size(); i++) chk("ign_data", beats[i], 8'hA0 + i);
    check_common("ign", 8);
    chk("ign_idle_after", busy, 0);

    // Asynchronous reset after three beats
    clear_mon();
    c0 = gcyc; base_addr = 16'h0010; length = 16'd8; start = 1'b1; m_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 50 && acc < 3; i++) tick();
    chk("rst_three_beats", acc, 3);
    chk("rst_busy_before", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_outputs", {busy, done, sram_en, sram_we, sram_addr, m_valid, m_data, m_last}, 0);
    tick(); tick();
    rst = 1'b1;
    m_ready = 1'b0;
    chk("rst_no_done", done_cnt, 0);
    chk("rst_done_low", done, 0);
    run("post_rst", 16'h0020, 16'd2, 0, 1'b0);
    chk("post_rst_first_valid", first_valid, 3);
    if (beats.size() == 2) begin
      chk("post_rst_d0", beats[0], 8'h55);
      chk("post_rst_d1", beats[1], 8'h66);
    end
    check_common("post_rst", 2);

    // Single word
    run("single", 16'h0040, 16'd1, 0, 1'b0);
    if (beats.size() == 1) chk("single_data", beats[0], 8'h5A);
    check_common("single", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_stream_reader.md
Name: sram_stream_reader

Overview:
- Read-side initiator for one bank of the multi-SRAM array. It drives that bank's en/we/addr port and consumes its data_o.
- Given a base address and a word count, it issues sequential reads and absorbs the SRAM's one-cycle read latency in a credit-controlled FIFO.
- It presents the words as a valid/ready stream to downstream compute (PE feeders, activation units).
- Bank muxing is external: this block sees one bank only.

Parameters:
DATA_WIDTH, 8, word width of the target SRAM bank and of m_data
ADDR_WIDTH, 16, SRAM address width (matches MAX_ADDR_WIDTH)
LEN_WIDTH, 16, width of the transfer length field
FIFO_DEPTH, 4, output buffer depth in words; must be a power of two, >= 4

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
start  input  1  one-cycle request; sampled only in IDLE
base_addr  input  ADDR_WIDTH  first word address, captured with start
length  input  LEN_WIDTH  number of words to read, captured with start
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse after the last beat is accepted
sram_en  output  1  read strobe to SRAM bank
sram_we  output  1  held 0 (read-only initiator)
sram_addr  output  ADDR_WIDTH  read address
sram_data  input  DATA_WIDTH  SRAM data_o; valid the cycle after sram_en
m_valid  output  1  stream data valid
m_ready  input  1  downstream accept
m_data  output  DATA_WIDTH  stream word (FIFO head)
m_last  output  1  high with the final word of the transfer

Behaviour:
- Reset (rst=0, asynchronous):
  - State returns to IDLE; FIFO, counters and the in-flight flag are cleared.
  - All outputs are 0: busy, done, sram_en, sram_we, sram_addr, m_valid, m_data, m_last.
  - Reset mid-transfer discards the transfer; no done pulse is generated.
  - After rst deasserts, start is honoured on the next rising edge.
- States are IDLE, READ and DRAIN.
- IDLE:
  - start=1 with length>0: capture base_addr/length and go to READ. issue_cnt and beat_cnt are set to 0; busy goes high the next cycle.
  - start=1 with length==0: stay in IDLE, issue no reads, pulse done the next cycle; busy stays 0.
- READ:
  - A read issues in a cycle when credit is available:
    - credit: fifo_count + inflight - pop < FIFO_DEPTH
    - inflight: 1 if sram_en was high last cycle
    - pop: m_valid & m_ready
  - On issue: sram_en=1 and sram_addr = base + issue_cnt (modulo 2^ADDR_WIDTH, wrapping silently); issue_cnt increments.
  - When issue_cnt reaches length after an issue, go to DRAIN.
- Capture:
  - If sram_en was high in cycle N, sram_data is pushed into the FIFO at the end of cycle N+1.
  - A push and a pop in the same cycle are both honoured.
  - The FIFO never overflows by construction; an overflow is an assertion failure.
- DRAIN:
  - No new reads are issued.
  - When the beat with beat_cnt == length-1 is accepted, go to IDLE and assert done in the following cycle; busy drops in that same cycle.
- Stream output:
  - m_valid = FIFO not empty; m_data = FIFO head.
  - m_data and m_valid stay stable while m_valid=1 and m_ready=0.
  - beat_cnt increments on each accept.
  - m_last = m_valid & (beat_cnt == length-1).
- Latency and throughput:
  - start accepted in cycle 0; first sram_en in cycle 1; first m_valid in cycle 3.
  - With m_ready held high, throughput is 1 word/cycle after fill, with no bubbles.
- start is ignored while busy; length and base_addr changes during a transfer have no effect.
- m_ready=0 for any duration: the FIFO fills, issue stalls, no data is lost or duplicated, and order is preserved.

Test Plan:
- Basic read: preload bank addr 0x10..0x17 with 0xA0..0xA7; start base=0x10 len=8, m_ready=1 -> first m_valid in cycle 3, 8 consecutive beats 0xA0..0xA7, m_last on 0xA7, done pulses 1 cycle after, busy low thereafter.
- Backpressure: same transfer with m_ready toggling 1,0,0,1 and a 10-cycle 0 stall mid-stream -> exact sequence 0xA0..0xA7 with no loss or duplication, no sram_en while the FIFO is full, m_data stable while stalled.
- Wrap: ADDR_WIDTH=16, base=0xFFFE, len=4 -> sram_addr sequence 0xFFFE,0xFFFF,0x0000,0x0001; data matches those locations.
- Zero length and ignored start: start len=0 -> done pulse next cycle, no sram_en, busy stays 0; start pulsed during a busy transfer -> ignored, first transfer completes unchanged.
- Async reset mid-transfer: assert rst=0 between clock edges after 3 beats of a len=8 transfer -> all outputs 0 immediately, no done; a new start base=0x20 len=2 after release -> correct 2 beats.
- Single word: len=1 -> one sram_en, one beat with m_last=1, done the cycle after acceptance.
